pc_fetch: RTL and testbench

Program counter and instruction-fetch sequencer for the RISC-V core. It holds the PC, issues fetch requests to instruction memory with a req/ack handshake, and presents each fetched instruction to decode with a valid/ready handshake. When decode accepts an instruction, it samples the branch decision `PCSrc` from the branch-condition stage. The next PC is then either PC+4 or PC+`imm_ext`.

---
 rtl/pc_fetch_if.sv | 28 ++
 rtl/pc_fetch.sv | 132 +++++++++++++
 tb/tb_pc_fetch.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
//   Bundles the two handshakes of the fetch sequencer:
//     - instruction-memory port: imem_req/imem_addr out, imem_ack/imem_rdata in
//     - decode port: instr_valid/instr_out/pc_out out, instr_ready in
//   master : the fetch sequencer (pc_fetch)
//   slave  : the memory / decode side
// -----------------------------------------------------------------------------
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, pc_out,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Program counter and instruction-fetch sequencer. Fetches the word at PC
//   over a req/ack handshake, presents it to decode over valid/ready, and on
//   acceptance moves PC to PC+4 or PC+imm_ext depending on PCSrc. A misaligned
//   target freezes the block in TRAP with a sticky misalign_err until rst.
//
// Ports
//   clk          : clock, rising edge
//   rst          : synchronous, active-high reset
//   PCSrc        : branch taken for the presented instruction
//   imm_ext      : sign-extended branch offset of the presented instruction
//   bus          : pc_fetch_if.master (imem req/ack port, decode valid/ready)
//   misalign_err : sticky misaligned-target flag
//   retired_cnt  : accepted-instruction count (0 when counters disabled)
//   taken_cnt    : taken-branch count (0 when counters disabled)
//
// Configuration
//   PC_FETCH_PERF_CNT_EN : when defined, builds the retired/taken counters;
//                          otherwise both count ports are tied to zero.
// -----------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] imm_ext,
    pc_fetch_if.master  bus,
    output logic        misalign_err,
    output logic [31:0] retired_cnt,
    output logic [31:0] taken_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
    logic        accept;
    logic [31:0] target;

    assign accept = (state == ISSUE) && bus.instr_ready;
    assign target = pc + (PCSrc ? imm_ext : 32'd4);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            instr_q      <= 32'h0;
            misalign_err <= 1'b0;
            req_q        <= 1'b1;
            valid_q      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        state   <= ISSUE;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        if (target[1:0] == 2'b00) begin
                            pc    <= target;
                            state <= FETCH;
                            req_q <= 1'b1;
                        end else begin
                            misalign_err <= 1'b1;
                            state        <= TRAP;
                        end
                    end
                end
                TRAP: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= TRAP;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The registered request/valid follow the state; while rst is held they
    // are masked so nothing is offered to memory or decode during reset.
    assign bus.imem_req    = req_q & ~rst;
    assign bus.instr_valid = valid_q & ~rst;
    assign bus.imem_addr   = pc;
    assign bus.pc_out      = pc;
    assign bus.instr_out   = instr_q;

`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] retired_q;
    logic [31:0] taken_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 32'h0;
            taken_q   <= 32'h0;
        end else if (accept) begin
            // Counted even when the accept traps on a misaligned target.
            retired_q <= retired_q + 32'd1;
            if (PCSrc) begin
                taken_q <= taken_q + 32'd1;
            end
        end
    end

    assign retired_cnt = retired_q;
    assign taken_cnt   = taken_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign retired_cnt   = 32'h0;
    assign taken_cnt     = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch
//   Drives pc_fetch cycle by cycle (directed scenarios, then random traffic)
//   and compares every output against a transaction-level reference model:
//   "holding an instruction or not", "trapped or not", current PC, counts.
// -----------------------------------------------------------------------------
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcsrc;
    logic [31:0] imm_ext;
    logic        misalign_err;
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrc        (pcsrc),
        .imm_ext      (imm_ext),
        .bus          (bus.master),
        .misalign_err (misalign_err),
        .retired_cnt  (retired_cnt),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_have;     // an instruction is waiting for decode
    logic        m_trap;
    logic [31:0] m_retired;
    logic [31:0] m_taken;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instr   = 32'h0;
        m_have    = 1'b0;
        m_trap    = 1'b0;
        m_retired = 32'h0;
        m_taken   = 32'h0;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    task automatic cyc(input logic r, input logic ack, input logic [31:0] rdata,
                       input logic rdy, input logic src, input logic [31:0] imm);
        logic [31:0] tgt;
        rst              = r;
        bus.imem_ack     = ack;
        bus.imem_rdata   = rdata;
        bus.instr_ready  = rdy;
        pcsrc            = src;
        imm_ext          = imm;
        @(negedge clk);
        check("imem_req",    {31'h0, bus.imem_req},    {31'h0, ~r & ~m_trap & ~m_have});
        check("instr_valid", {31'h0, bus.instr_valid}, {31'h0, ~r & ~m_trap & m_have});
        check("imem_addr",   bus.imem_addr, m_pc);
        check("pc_out",      bus.pc_out,    m_pc);
        check("instr_out",   bus.instr_out, m_instr);
        check("misalign",    {31'h0, misalign_err}, {31'h0, m_trap});
`ifdef PC_FETCH_PERF_CNT_EN
        check("retired_cnt", retired_cnt, m_retired);
        check("taken_cnt",   taken_cnt,   m_taken);
`else
        check("retired_cnt", retired_cnt, 32'h0);
        check("taken_cnt",   taken_cnt,   32'h0);
`endif
        if (r) begin
            model_reset();
        end else if (!m_trap) begin
            if (!m_have) begin
                if (ack) begin
                    m_instr = rdata;
                    m_have  = 1'b1;
                end
            end else if (rdy) begin
                m_retired = m_retired + 1;
                if (src) m_taken = m_taken + 1;
                tgt = src ? m_pc + imm : m_pc + 32'd4;
                if (tgt % 4 != 0) begin
                    m_trap = 1'b1;
                end else begin
                    m_pc   = tgt;
                    m_have = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Fetch one word (immediate ack) and accept it with the given branch.
    task automatic one_instr(input logic [31:0] word, input logic src, input logic [31:0] imm);
        cyc(1'b0, 1'b1, word, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, $urandom, 1'b1, src, imm);
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.instr_ready = 1'b0;
        pcsrc = 1'b0;
        imm_ext = 32'h0;
        @(posedge clk);
        #1;
        model_reset();
        do_reset();

        // Sequential fetch: ack and ready always high.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 32'h1000 + i, 1'b1, 1'b0, 32'h0);
        check("seq_addr_after_3", bus.imem_addr, 32'hC);
`ifdef PC_FETCH_PERF_CNT_EN
        check("seq_retired_3", retired_cnt, 32'd3);
`endif

        // Taken branch backwards: PC 0x10 + (-8) = 0x08.
        one_instr(32'hAAAA_0001, 1'b0, 32'h0);                 // 0xC -> 0x10
        check("at_0x10", bus.imem_addr, 32'h10);
        one_instr(32'hAAAA_0002, 1'b1, 32'hFFFF_FFF8);
        check("branch_back", bus.imem_addr, 32'h08);

        // Back-pressure: ack delayed 3 cycles, ready low 2 cycles, PCSrc toggling.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, $urandom, 1'b1, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 32'hBEEF_0003, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, i[0], 32'h40);
        check("bp_instr_held", bus.instr_out, 32'hBEEF_0003);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40);
        check("bp_next_addr", bus.imem_addr, 32'h0C);

        // Misaligned target from PC 0x20.
        do_reset();
        one_instr(32'h1, 1'b1, 32'h20);
        check("at_0x20", bus.imem_addr, 32'h20);
        one_instr(32'h2, 1'b1, 32'h6);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
        check("trap_pc", bus.pc_out, 32'h20);
        check("trap_flag", {31'h0, misalign_err}, 32'h1);

        // Wrap at the top of the address space, then reset with a live ack.
        do_reset();
        one_instr(32'h3, 1'b1, 32'hFFFF_FFFC);
        check("at_top", bus.imem_addr, 32'hFFFF_FFFC);
        one_instr(32'h4, 1'b0, 32'h0);
        check("wrap_addr", bus.imem_addr, 32'h0);
        one_instr(32'h5, 1'b0, 32'h0);                         // now at 0x4, FETCH
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check("rst_ack_ignored", bus.instr_out, 32'h0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int          k;
            logic [31:0] imm;
            k   = int'($urandom_range(0, 32)) - 16;
            imm = 32'(k * 4);
            if ($urandom_range(0, 19) == 0) imm = imm | 32'($urandom_range(1, 3));
            cyc((m_trap && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0,
                1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), imm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
